// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared widths, opcode constants and queue entry type for the
//               instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    localparam logic [3:0] OP_J = 4'hC;

    typedef struct packed {
        logic [DSIZE-1:0] inst;
        logic [ISIZE-1:0] npc;
    } fetch_entry_t;

    // Direct jump keeps the page bits of the sequential successor.
    function automatic logic [ISIZE-1:0] jump_target(
        input logic [ISIZE-1:0] npc,
        input logic [DSIZE-1:0] inst
    );
        return {npc[ISIZE-1 -: 4], inst[11:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry circular instruction queue with flush; the head
//               is presented combinationally, last head held while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         valid,
    output logic         full,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    fetch_entry_t     r_hold;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_empty = (r_count == '0);
    assign w_pop   = pop & ~w_empty;
    assign w_push  = push & ((r_count != C_FULL) | w_pop);

    assign valid = ~w_empty;
    assign full  = (r_count == C_FULL);
    assign head  = w_empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (!w_empty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch with a single outstanding imem request,
//               redirect flush and stale-response discard. Define
//               FETCH_JUMP_PREDECODE_EN to follow OP_J jumps at fetch time.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [ISIZE-1:0] imem_addr,
    input  logic             imem_valid,
    input  logic [DSIZE-1:0] imem_rdata,
    output logic             inst_valid,
    output logic [DSIZE-1:0] inst_out,
    output logic [ISIZE-1:0] npc_out,
    input  logic             inst_ready,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc
);

    logic [ISIZE-1:0] r_fetch_pc;
    logic             r_outstanding;
    logic             r_discard;
    logic [ISIZE-1:0] w_seq_pc;
    logic [ISIZE-1:0] w_next_pc;
    logic             w_issue;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;

    // The request is a combinational strobe; it is taken by memory at the
    // edge that ends the cycle, which also marks it outstanding.
    assign w_issue  = rst & ~r_outstanding & ~redirect_valid & ~w_full;
    assign w_accept = imem_valid & r_outstanding;
    assign w_push   = w_accept & ~r_discard & ~redirect_valid;
    assign w_pop    = inst_valid & inst_ready & ~redirect_valid;
    assign w_seq_pc = r_fetch_pc + 1'b1;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign w_next_pc = (imem_rdata[DSIZE-1 -: 4] == OP_J) ?
                       jump_target(w_seq_pc, imem_rdata) : w_seq_pc;
`else
    assign w_next_pc = w_seq_pc;
`endif

    assign w_push_data.inst = imem_rdata;
    assign w_push_data.npc  = w_seq_pc;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign inst_out  = w_head.inst;
    assign npc_out   = w_head.npc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            // A response landing with the redirect is consumed and dropped
            // here; otherwise the in-flight one is marked for discard.
            if (r_outstanding) begin
                r_outstanding <= ~imem_valid;
                r_discard     <= ~imem_valid;
            end
        end else if (w_issue) begin
            r_outstanding <= 1'b1;
        end else if (w_accept) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            if (!r_discard) begin
                r_fetch_pc <= w_next_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .valid     (inst_valid),
        .full      (w_full),
        .head      (w_head)
    );

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  out  ISIZE  fetch address; valid while imem_req=1.
REQ-007 SHALL have port imem_valid  in  1  response strobe for the single outstanding request.
REQ-008 SHALL have port imem_rdata  in  DSIZE  fetched instruction; valid with imem_valid.
REQ-009 SHALL have port inst_valid  out  1  queue head holds an instruction.
REQ-010 SHALL have port inst_out  out  DSIZE  head instruction toward the ID_EXE pipeline register.
REQ-011 SHALL have port npc_out  out  ISIZE  head instruction address + 1, used for branch-adder and jal link input.
REQ-012 SHALL have port inst_ready  in  1  decode accepts head; pop when inst_valid & inst_ready.
REQ-013 SHALL have port redirect_valid  in  1  branch/jump/jr taken; flush and restart fetch.
REQ-014 SHALL have port redirect_pc  in  ISIZE  restart address, sampled with redirect_valid.

Function
REQ-015 SHALL allow at most one outstanding imem request; imem_req pulses one cycle per request, imem_addr = fetch PC.
REQ-016 SHALL issue a request only when no request is outstanding, no redirect is asserted, and queue count < DEPTH.
REQ-017 SHALL accept imem_valid any cycle >=1 after request; on accept push {imem_rdata, addr+1} and fetch PC += 1.
REQ-018 SHALL wrap fetch PC and npc modulo 2^16 (16'hFFFF + 1 = 16'h0000).
REQ-019 SHALL present inst_out/npc_out from queue head combinationally; an empty queue gives inst_valid=0, inst_out/npc_out held.
REQ-020 SHALL support push and pop in the same cycle when full or empty-with-bypass-free (count unchanged when both occur and count>0).
REQ-021 SHALL not bypass: an instruction becomes visible the cycle after its imem_valid (min fetch-to-decode latency 2 cycles).
REQ-022 SHALL on redirect_valid: empty queue, fetch PC <= redirect_pc, inst_valid=0 next cycle; redirect wins over simultaneous pop and push.
REQ-023 SHALL, if a request is outstanding at redirect, set a discard flag and drop that response; next request issues the cycle after the drop.
REQ-024 SHALL treat imem_valid with no outstanding request as a protocol error and ignore it.

Reset
REQ-025 SHALL on rst=0 immediately clear: queue count, pointers, outstanding and discard flags; fetch PC=RESET_PC; imem_req=0; inst_valid=0; inst_out=0; npc_out=0.
REQ-026 SHALL issue the first request (addr RESET_PC) on the first clk edge after rst deasserts; responses arriving during reset are lost.

Configuration
REQ-027 SHALL, with FETCH_JUMP_PREDECODE_EN defined, predecode each response: if imem_rdata[15:12]==OP_J, push it and set fetch PC to {addr+1[15:12], imem_rdata[11:0]} instead of addr+1.
REQ-028 SHALL, without FETCH_JUMP_PREDECODE_EN, fetch strictly sequentially; jumps are resolved only via redirect.

Structure
REQ-029 SHALL take ISIZE, DSIZE and the opcode constant OP_J from the shared definitions package/header.
REQ-030 SHALL instantiate one sub-module fetch_queue (DEPTH-entry circular FIFO, pointers wrap at DEPTH, flush input); PC/request control stays in the top.

Verification
REQ-031 SHALL test: reset, memory latency 1, inst_ready=1 -> addresses 0,1,2,3 fetched; inst_out order matches; npc_out 1,2,3,4.
REQ-032 SHALL test: inst_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests, imem_req stays 0 afterwards, inst_valid=1 with first word.
REQ-033 SHALL test: redirect_pc=16'h0040 while request to 16'h0005 outstanding, latency 3 -> stale word dropped, next imem_addr=16'h0040, no stale inst_valid.
REQ-034 SHALL test: redirect, pop and imem_valid in same cycle -> queue empty next cycle, fetch resumes at redirect_pc.
REQ-035 SHALL test: RESET_PC=16'hFFFE -> fetched addresses FFFE, FFFF, 0000; npc_out FFFF, 0000, 0001.
REQ-036 SHALL test: FETCH_JUMP_PREDECODE_EN defined, word at 16'h0002 is OP_J with target 12'h123 -> next imem_addr=16'h0123; undefined -> 16'h0003.
